// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: arbitrates ROB stores, LB loads and IF fetches onto an 8-bit RAM port, one byte per cycle.
// Optional macro IO_STALL_EN: IO-mapped store bytes wait while io_buffer_full_in is high.
package mem_bus_ctrl_pkg;
  localparam int unsigned INST_TYPE_WIDTH = 4;
  localparam logic [INST_TYPE_WIDTH-1:0] LB  = 4'd0;
  localparam logic [INST_TYPE_WIDTH-1:0] LH  = 4'd1;
  localparam logic [INST_TYPE_WIDTH-1:0] LW  = 4'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] LBU = 4'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] LHU = 4'd4;
  localparam logic [INST_TYPE_WIDTH-1:0] SB  = 4'd5;
  localparam logic [INST_TYPE_WIDTH-1:0] SH  = 4'd6;
  localparam logic [INST_TYPE_WIDTH-1:0] SW  = 4'd7;
endpackage

module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       rob_en_in,
  input  logic [ADDR_W-1:0]          rob_addr_in,
  input  logic [31:0]                rob_wdata_in,
  input  logic [INST_TYPE_WIDTH-1:0] rob_inst_type_in,
  output logic                       rob_rdy_out,
  output logic                       rob_finish_out,
  input  logic                       lb_en_in,
  input  logic [ADDR_W-1:0]          lb_addr_in,
  input  logic [INST_TYPE_WIDTH-1:0] lb_inst_type_in,
  output logic                       lb_done_out,
  output logic [31:0]                lb_data_out,
  input  logic                       if_en_in,
  input  logic [ADDR_W-1:0]          if_pc_in,
  output logic                       if_done_out,
  output logic [31:0]                if_inst_out,
  input  logic [7:0]                 mem_din_in,
  output logic [7:0]                 mem_dout_out,
  output logic [ADDR_W-1:0]          mem_a_out,
  output logic                       mem_wr_out,
  input  logic                       io_buffer_full_in
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {IDLE, ST_WAIT, STORE, LOAD, FETCH} state_t;

  state_t                     r_state, w_state;
  logic [ADDR_W-1:0]          r_addr, w_addr;
  logic [DATA_W-1:0]          r_wdata, w_wdata;
  logic [INST_TYPE_WIDTH-1:0] r_type, w_type;
  logic [CNT_W-1:0]           r_nbytes, w_nbytes;
  logic [CNT_W-1:0]           r_cnt, w_cnt;
  logic [DATA_W-1:0]          r_buf, w_buf;
  logic                       r_mem_wr, w_mem_wr;
  logic [ADDR_W-1:0]          r_mem_a, w_mem_a;
  logic [7:0]                 r_mem_dout, w_mem_dout;
  logic                       r_rob_finish, w_rob_finish;
  logic                       r_lb_done, w_lb_done;
  logic [DATA_W-1:0]          r_lb_data, w_lb_data;
  logic                       r_if_done, w_if_done;
  logic [DATA_W-1:0]          r_if_inst, w_if_inst;

  logic                       w_rob_rdy;
  logic                       w_io_stall;
  logic [ADDR_W-1:0]          w_byte_addr;
  logic [CNT_W-1:0]           w_cnt_inc;
  logic [1:0]                 w_rx_idx;

  function automatic logic [CNT_W-1:0] load_bytes(input logic [INST_TYPE_WIDTH-1:0] t);
    case (t)
      LB, LBU: load_bytes = CNT_W'(1);
      LH, LHU: load_bytes = CNT_W'(2);
      default: load_bytes = CNT_W'(4);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] store_bytes(input logic [INST_TYPE_WIDTH-1:0] t);
    case (t)
      SB:      store_bytes = CNT_W'(1);
      SH:      store_bytes = CNT_W'(2);
      default: store_bytes = CNT_W'(4);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [INST_TYPE_WIDTH-1:0] t,
                                               input logic [DATA_W-1:0] w);
    case (t)
      LB:      extend = {{24{w[7]}}, w[7:0]};
      LH:      extend = {{16{w[15]}}, w[15:0]};
      LBU:     extend = {24'h0, w[7:0]};
      LHU:     extend = {16'h0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  assign w_rob_rdy   = (r_state == IDLE) && !r_rob_finish;
  assign w_byte_addr = r_addr + ADDR_W'(r_cnt);
  assign w_cnt_inc   = CNT_W'(r_cnt + CNT_W'(1));
  // Read data lags its address by one cycle, so byte cnt-1 arrives while cnt is current.
  assign w_rx_idx    = 2'(r_cnt - CNT_W'(1));

`ifdef IO_STALL_EN
  assign w_io_stall = io_buffer_full_in && (w_byte_addr >= IO_BASE);
`else
  logic w_io_full_unused;
  assign w_io_full_unused = io_buffer_full_in;
  assign w_io_stall       = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state      = r_state;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_type       = r_type;
    w_nbytes     = r_nbytes;
    w_cnt        = r_cnt;
    w_buf        = r_buf;
    w_mem_wr     = 1'b0;
    w_mem_a      = r_mem_a;
    w_mem_dout   = r_mem_dout;
    w_rob_finish = 1'b0;
    w_lb_done    = 1'b0;
    w_lb_data    = r_lb_data;
    w_if_done    = 1'b0;
    w_if_inst    = r_if_inst;

    case (r_state)
      IDLE: begin
        if (rob_en_in && w_rob_rdy) begin
          w_state = ST_WAIT;
        end else if (!flush_in && lb_en_in) begin
          w_state  = LOAD;
          w_addr   = lb_addr_in;
          w_type   = lb_inst_type_in;
          w_nbytes = load_bytes(lb_inst_type_in);
          w_cnt    = '0;
          w_buf    = '0;
          w_mem_a  = lb_addr_in;
        end else if (!flush_in && if_en_in) begin
          w_state  = FETCH;
          w_addr   = if_pc_in;
          w_type   = LW;
          w_nbytes = CNT_W'(4);
          w_cnt    = '0;
          w_buf    = '0;
          w_mem_a  = if_pc_in;
        end
      end

      ST_WAIT: begin
        w_state  = STORE;
        w_addr   = rob_addr_in;
        w_wdata  = rob_wdata_in;
        w_nbytes = store_bytes(rob_inst_type_in);
        w_cnt    = '0;
      end

      STORE: begin
        if (r_cnt == r_nbytes) begin
          w_state      = IDLE;
          w_rob_finish = 1'b1;
        end else if (!w_io_stall) begin
          w_mem_wr   = 1'b1;
          w_mem_a    = w_byte_addr;
          w_mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
          w_cnt      = w_cnt_inc;
        end
      end

      LOAD, FETCH: begin
        if (flush_in) begin
          w_state = IDLE;
        end else begin
          if (r_cnt != '0) begin
            w_buf[{w_rx_idx, 3'b000} +: 8] = mem_din_in;
          end
          if (w_cnt_inc < r_nbytes) begin
            w_mem_a = r_addr + ADDR_W'(w_cnt_inc);
          end
          w_cnt = w_cnt_inc;
          if (r_cnt == r_nbytes) begin
            w_state = IDLE;
            if (r_state == FETCH) begin
              w_if_done = 1'b1;
              w_if_inst = w_buf;
            end else begin
              w_lb_done = 1'b1;
              w_lb_data = extend(r_type, w_buf);
            end
          end
        end
      end

      default: w_state = IDLE;
    endcase
  end

  // State and output registers; rdy_in low freezes everything
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_type       <= '0;
      r_nbytes     <= '0;
      r_cnt        <= '0;
      r_buf        <= '0;
      r_mem_wr     <= 1'b0;
      r_mem_a      <= '0;
      r_mem_dout   <= '0;
      r_rob_finish <= 1'b0;
      r_lb_done    <= 1'b0;
      r_lb_data    <= '0;
      r_if_done    <= 1'b0;
      r_if_inst    <= '0;
    end else if (rdy_in) begin
      r_state      <= w_state;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_type       <= w_type;
      r_nbytes     <= w_nbytes;
      r_cnt        <= w_cnt;
      r_buf        <= w_buf;
      r_mem_wr     <= w_mem_wr;
      r_mem_a      <= w_mem_a;
      r_mem_dout   <= w_mem_dout;
      r_rob_finish <= w_rob_finish;
      r_lb_done    <= w_lb_done;
      r_lb_data    <= w_lb_data;
      r_if_done    <= w_if_done;
      r_if_inst    <= w_if_inst;
    end
  end

  assign rob_rdy_out    = w_rob_rdy;
  assign rob_finish_out = r_rob_finish;
  assign lb_done_out    = r_lb_done;
  assign lb_data_out    = r_lb_data;
  assign if_done_out    = r_if_done;
  assign if_inst_out    = r_if_inst;
  assign mem_wr_out     = r_mem_wr;
  assign mem_a_out      = r_mem_a;
  assign mem_dout_out   = r_mem_dout;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl with a 1 KiB byte RAM that has one cycle of read latency.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        rob_en_in;
  logic [31:0] rob_addr_in, rob_wdata_in;
  logic [INST_TYPE_WIDTH-1:0] rob_inst_type_in, lb_inst_type_in;
  logic        rob_rdy_out, rob_finish_out;
  logic        lb_en_in;
  logic [31:0] lb_addr_in, lb_data_out;
  logic        lb_done_out;
  logic        if_en_in;
  logic [31:0] if_pc_in, if_inst_out;
  logic        if_done_out;
  logic [7:0]  mem_din_in, mem_dout_out;
  logic [31:0] mem_a_out;
  logic        mem_wr_out;
  logic        io_buffer_full_in;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:1023];
  logic [7:0] ram_q;
  logic       tb_wr = 1'b0;
  logic [9:0] tb_wa = '0;
  logic [7:0] tb_wd = '0;

  always #5 clk_in = ~clk_in;

  mem_bus_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .rob_en_in(rob_en_in), .rob_addr_in(rob_addr_in), .rob_wdata_in(rob_wdata_in),
    .rob_inst_type_in(rob_inst_type_in), .rob_rdy_out(rob_rdy_out), .rob_finish_out(rob_finish_out),
    .lb_en_in(lb_en_in), .lb_addr_in(lb_addr_in), .lb_inst_type_in(lb_inst_type_in),
    .lb_done_out(lb_done_out), .lb_data_out(lb_data_out),
    .if_en_in(if_en_in), .if_pc_in(if_pc_in), .if_done_out(if_done_out), .if_inst_out(if_inst_out),
    .mem_din_in(mem_din_in), .mem_dout_out(mem_dout_out), .mem_a_out(mem_a_out),
    .mem_wr_out(mem_wr_out), .io_buffer_full_in(io_buffer_full_in)
  );

  // RAM stalls together with the core when rdy_in is low
  always @(posedge clk_in) begin
    if (tb_wr) ram[tb_wa] <= tb_wd;
    else if (rdy_in && mem_wr_out) ram[mem_a_out[9:0]] <= mem_dout_out;
    if (rdy_in) ram_q <= ram[mem_a_out[9:0]];
  end
  assign mem_din_in = ram_q;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    tb_wr = 1'b1; tb_wa = a[9:0]; tb_wd = d;
    tick;
    tb_wr = 1'b0;
  endtask

  task automatic store_seq(input logic [31:0] a, input logic [31:0] d,
                           input logic [INST_TYPE_WIDTH-1:0] t, input int n);
    rob_en_in = 1'b1; rob_addr_in = a; rob_wdata_in = d; rob_inst_type_in = t;
    tick;
    rob_en_in = 1'b0;
    checks++;
    if (rob_rdy_out !== 1'b0) begin
      errors++; $display("FAIL st_wait_rdy got %b want 0", rob_rdy_out);
    end
    tick;
    rob_addr_in = 32'hDEAD_BEEF; rob_wdata_in = 32'h5555_5555; rob_inst_type_in = SB;
    for (int k = 0; k < n; k++) begin
      tick;
      checks++;
      if ({mem_wr_out, mem_a_out, mem_dout_out, rob_rdy_out, rob_finish_out} !==
          {1'b1, 32'(a + 32'(k)), 8'(d >> (8 * k)), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL st_byte%0d got wr=%b a=%h d=%h rdy=%b fin=%b want wr=1 a=%h d=%h rdy=0 fin=0",
                 k, mem_wr_out, mem_a_out, mem_dout_out, rob_rdy_out, rob_finish_out,
                 32'(a + 32'(k)), 8'(d >> (8 * k)));
      end
    end
    tick;
    checks++;
    if ({rob_finish_out, mem_wr_out, rob_rdy_out} !== 3'b100) begin
      errors++; $display("FAIL st_finish got fin=%b wr=%b rdy=%b want 1 0 0",
                         rob_finish_out, mem_wr_out, rob_rdy_out);
    end
    tick;
    checks++;
    if ({rob_finish_out, rob_rdy_out} !== 2'b01) begin
      errors++; $display("FAIL st_after got fin=%b rdy=%b want 0 1", rob_finish_out, rob_rdy_out);
    end
  endtask

  task automatic load_seq(input logic [31:0] a, input logic [INST_TYPE_WIDTH-1:0] t,
                          input int n, input logic [31:0] exp);
    lb_en_in = 1'b1; lb_addr_in = a; lb_inst_type_in = t;
    tick;
    checks++;
    if (mem_a_out !== a) begin
      errors++; $display("FAIL ld_addr0 got %h want %h", mem_a_out, a);
    end
    for (int c = 1; c <= n; c++) begin
      tick;
      checks++;
      if (lb_done_out !== 1'b0) begin
        errors++; $display("FAIL ld_early_done cycle %0d got %b want 0", c, lb_done_out);
      end
    end
    tick;
    checks++;
    if ({lb_done_out, lb_data_out} !== {1'b1, exp}) begin
      errors++; $display("FAIL ld_data got done=%b data=%h want done=1 data=%h", lb_done_out, lb_data_out, exp);
    end
    lb_en_in = 1'b0;
    tick;
    checks++;
    if (lb_done_out !== 1'b0) begin
      errors++; $display("FAIL ld_pulse got %b want 0", lb_done_out);
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full_in = 1'b0;
    rob_en_in = 1'b0; rob_addr_in = '0; rob_wdata_in = '0; rob_inst_type_in = SB;
    lb_en_in = 1'b0; lb_addr_in = '0; lb_inst_type_in = LB;
    if_en_in = 1'b0; if_pc_in = '0;
    tick; tick;
    checks++;
    if ({mem_wr_out, mem_a_out, mem_dout_out, rob_finish_out, lb_done_out, lb_data_out,
         if_done_out, if_inst_out} !== 108'h0) begin
      errors++; $display("FAIL reset_vals got wr=%b a=%h d=%h fin=%b ld=%b ldd=%h if=%b ifi=%h want all 0",
                         mem_wr_out, mem_a_out, mem_dout_out, rob_finish_out, lb_done_out,
                         lb_data_out, if_done_out, if_inst_out);
    end
    rst_in = 1'b1;
    tick;
    checks++;
    if (rob_rdy_out !== 1'b1) begin
      errors++; $display("FAIL reset_rdy got %b want 1", rob_rdy_out);
    end
  endtask

  task automatic test_store;
    store_seq(32'h100, 32'hA1B2_C3D4, SW, 4);
    checks++;
    if ({ram[10'h103], ram[10'h102], ram[10'h101], ram[10'h100]} !== 32'hA1B2_C3D4) begin
      errors++; $display("FAIL sw_ram got %h want a1b2c3d4",
                         {ram[10'h103], ram[10'h102], ram[10'h101], ram[10'h100]});
    end
    store_seq(32'h120, 32'h1234_ABCD, SH, 2);
    store_seq(32'hFFFF_FFFF, 32'h0000_6655, SH, 2);
    checks++;
    if ({ram[10'h000], ram[10'h3FF]} !== 16'h6655) begin
      errors++; $display("FAIL sh_wrap_ram got %h want 6655", {ram[10'h000], ram[10'h3FF]});
    end
  endtask

  task automatic test_load;
    poke(32'h200, 8'h80); poke(32'h201, 8'h81); poke(32'h202, 8'h82);
    poke(32'h203, 8'h83); poke(32'h204, 8'h7F);
    load_seq(32'h200, LB,  1, 32'hFFFF_FF80);
    load_seq(32'h200, LHU, 2, 32'h0000_8180);
    load_seq(32'h200, LH,  2, 32'hFFFF_8180);
    load_seq(32'h201, LBU, 1, 32'h0000_0081);
    load_seq(32'h201, LW,  4, 32'h7F83_8281);
  endtask

  task automatic test_simultaneous;
    int fin_c, ld_c, if_c;
    logic [31:0] ld_d, if_d;
    poke(32'h0, 8'h11); poke(32'h1, 8'h22); poke(32'h2, 8'h33); poke(32'h3, 8'h44);
    fin_c = -1; ld_c = -1; if_c = -1; ld_d = '0; if_d = '0;
    rob_en_in = 1'b1; rob_addr_in = 32'h300; rob_wdata_in = 32'h0000_BEEF; rob_inst_type_in = SH;
    lb_en_in = 1'b1; lb_addr_in = 32'h200; lb_inst_type_in = LBU;
    if_en_in = 1'b1; if_pc_in = 32'h0;
    tick;
    rob_en_in = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick;
      if (rob_finish_out && fin_c < 0) fin_c = c;
      if (lb_done_out && ld_c < 0) begin ld_c = c; ld_d = lb_data_out; lb_en_in = 1'b0; end
      if (if_done_out && if_c < 0) begin if_c = c; if_d = if_inst_out; if_en_in = 1'b0; end
    end
    lb_en_in = 1'b0; if_en_in = 1'b0;
    checks++;
    if ({fin_c, ld_c, if_c} !== {32'sd4, 32'sd7, 32'sd13}) begin
      errors++; $display("FAIL arb_order got fin@%0d ld@%0d if@%0d want 4 7 13", fin_c, ld_c, if_c);
    end
    checks++;
    if (ld_d !== 32'h0000_0080) begin
      errors++; $display("FAIL arb_ld_data got %h want 00000080", ld_d);
    end
    checks++;
    if (if_d !== 32'h4433_2211) begin
      errors++; $display("FAIL arb_if_inst got %h want 44332211", if_d);
    end
    checks++;
    if ({ram[10'h301], ram[10'h300]} !== 16'hBEEF) begin
      errors++; $display("FAIL arb_st_ram got %h want beef", {ram[10'h301], ram[10'h300]});
    end
  endtask

  task automatic test_flush;
    int pulses;
    if_en_in = 1'b1; if_pc_in = 32'h0;
    tick; tick; tick;
    flush_in = 1'b1; if_en_in = 1'b0;
    tick;
    checks++;
    if ({if_done_out, rob_rdy_out} !== 2'b01) begin
      errors++; $display("FAIL flush_fetch got done=%b rdy=%b want 0 1", if_done_out, rob_rdy_out);
    end
    flush_in = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (if_done_out) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL flush_no_done got %0d pulses want 0", pulses);
    end
    lb_en_in = 1'b1; lb_addr_in = 32'h200; lb_inst_type_in = LB; flush_in = 1'b1;
    tick;
    checks++;
    if (rob_rdy_out !== 1'b1) begin
      errors++; $display("FAIL flush_grant got rdy=%b want 1", rob_rdy_out);
    end
    flush_in = 1'b0;
    load_seq(32'h200, LB, 1, 32'hFFFF_FF80);
    flush_in = 1'b1;
    store_seq(32'h140, 32'h0102_0304, SW, 4);
    flush_in = 1'b0;
    checks++;
    if ({ram[10'h143], ram[10'h142], ram[10'h141], ram[10'h140]} !== 32'h0102_0304) begin
      errors++; $display("FAIL flush_st_ram got %h want 01020304",
                         {ram[10'h143], ram[10'h142], ram[10'h141], ram[10'h140]});
    end
  endtask

  task automatic test_rdy;
    lb_en_in = 1'b1; lb_addr_in = 32'h200; lb_inst_type_in = LW;
    tick; tick; tick;
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if ({lb_done_out, mem_a_out} !== {1'b0, 32'h202}) begin
        errors++; $display("FAIL rdy_frozen got done=%b a=%h want 0 00000202", lb_done_out, mem_a_out);
      end
    end
    rdy_in = 1'b1;
    tick; tick;
    checks++;
    if (lb_done_out !== 1'b0) begin
      errors++; $display("FAIL rdy_early_done got %b want 0", lb_done_out);
    end
    tick;
    checks++;
    if ({lb_done_out, lb_data_out} !== {1'b1, 32'h8382_8180}) begin
      errors++; $display("FAIL rdy_ld_data got done=%b data=%h want 1 83828180", lb_done_out, lb_data_out);
    end
    rdy_in = 1'b0; lb_en_in = 1'b0;
    tick;
    checks++;
    if (lb_done_out !== 1'b1) begin
      errors++; $display("FAIL rdy_pulse_hold got %b want 1", lb_done_out);
    end
    rdy_in = 1'b1;
    tick;
    checks++;
    if (lb_done_out !== 1'b0) begin
      errors++; $display("FAIL rdy_pulse_end got %b want 0", lb_done_out);
    end
  endtask

  task automatic test_reset_mid;
    int pulses, writes;
    poke(32'h182, 8'h00);
    rob_en_in = 1'b1; rob_addr_in = 32'h180; rob_wdata_in = 32'hCAFE_F00D; rob_inst_type_in = SW;
    tick;
    rob_en_in = 1'b0;
    tick; tick; tick;
    rst_in = 1'b0;
    tick;
    checks++;
    if ({mem_wr_out, mem_a_out, mem_dout_out, rob_finish_out, lb_done_out, lb_data_out,
         if_done_out, if_inst_out, rob_rdy_out} !== {108'h0, 1'b1}) begin
      errors++; $display("FAIL rstmid_vals got wr=%b a=%h d=%h fin=%b rdy=%b want 0 0 0 0 1",
                         mem_wr_out, mem_a_out, mem_dout_out, rob_finish_out, rob_rdy_out);
    end
    rst_in = 1'b1;
    pulses = 0; writes = 0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (rob_finish_out) pulses++;
      if (mem_wr_out) writes++;
    end
    checks++;
    if ({pulses, writes} !== 64'h0) begin
      errors++; $display("FAIL rstmid_quiet got fin=%0d wr=%0d want 0 0", pulses, writes);
    end
    checks++;
    if ({ram[10'h182], ram[10'h181]} !== 16'h00F0) begin
      errors++; $display("FAIL rstmid_ram got %h want 00f0", {ram[10'h182], ram[10'h181]});
    end
  endtask

  task automatic test_io_stall;
    int wr_c, fin_c, wr_n, exp_wr;
    logic [31:0] wr_a;
    logic [7:0]  wr_d;
`ifdef IO_STALL_EN
    exp_wr = 5;
`else
    exp_wr = 2;
`endif
    wr_c = -1; fin_c = -1; wr_n = 0; wr_a = '0; wr_d = '0;
    rob_en_in = 1'b1; rob_addr_in = 32'h3_0000; rob_wdata_in = 32'h0000_005A; rob_inst_type_in = SB;
    tick;
    rob_en_in = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick;
      if (mem_wr_out) begin
        wr_n++;
        if (wr_c < 0) begin wr_c = c; wr_a = mem_a_out; wr_d = mem_dout_out; end
      end
      if (rob_finish_out && fin_c < 0) fin_c = c;
      if (c == 1) io_buffer_full_in = 1'b1;
      if (c == 4) io_buffer_full_in = 1'b0;
    end
    checks++;
    if ({wr_c, fin_c, wr_n} !== {exp_wr, exp_wr + 1, 32'sd1}) begin
      errors++; $display("FAIL io_timing got wr@%0d fin@%0d nwr=%0d want %0d %0d 1",
                         wr_c, fin_c, wr_n, exp_wr, exp_wr + 1);
    end
    checks++;
    if ({wr_a, wr_d} !== {32'h3_0000, 8'h5A}) begin
      errors++; $display("FAIL io_byte got a=%h d=%h want 00030000 5a", wr_a, wr_d);
    end
  endtask

  initial begin
    test_reset;
    test_store;
    test_load;
    test_simultaneous;
    test_flush;
    test_rdy;
    test_reset_mid;
    test_io_stall;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
